// File: rtl/addr_bus_arbiter.sv
// -----------------------------------------------------------------------------
// addr_bus_arbiter
//
// Shares the on-chip register bus among NUM_MASTERS requesters. The bus has a
// 31-bit address and 32-bit data. The requesters are the XLink data processor,
// the USB command engine and spare ports. Grants rotate round-robin.
//
// Each granted request becomes one single-cycle rd_strobe/wr_strobe bus cycle.
// Slave read data is captured RD_LATENCY cycles after the strobe. It is then
// returned to the owner together with a one-cycle m_ack pulse.
//
// Transaction sequence: IDLE -> STROBE -> WAIT -> ACK -> IDLE
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   m_req        per-master request (level)
//   m_we         per-master direction, 1 = write
//   m_lock       per-master lock request (used only with ADDR_ARB_LOCK_EN)
//   m_addr       flattened addresses, master i at [31*i+30:31*i]
//   m_wdata      flattened write data, master i at [32*i+31:32*i]
//   m_ack        one-hot completion pulse
//   m_rdata      read data, valid with m_ack, held until the next capture
//   addr_bus     shared bus address (0 when idle)
//   data_bus_wr  shared bus write data (0 when idle)
//   data_bus_rd  OR-combined slave read data
//   wr_strobe    single-cycle write strobe
//   rd_strobe    single-cycle read strobe
//   grant        one-hot current owner, 0 when idle
//
// Build option
//   ADDR_ARB_LOCK_EN
//     When defined, an owner that holds m_lock high in its ACK cycle keeps
//     the bus for its next transaction (used for atomic read-modify-write).
//     When undefined, m_lock is ignored and arbitration is pure round robin.
// -----------------------------------------------------------------------------
module addr_bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int RD_LATENCY  = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_MASTERS-1:0]    m_req,
   input  logic [NUM_MASTERS-1:0]    m_we,
   input  logic [NUM_MASTERS-1:0]    m_lock,
   input  logic [31*NUM_MASTERS-1:0] m_addr,
   input  logic [32*NUM_MASTERS-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]    m_ack,
   output logic [31:0]               m_rdata,
   output logic [30:0]               addr_bus,
   output logic [31:0]               data_bus_wr,
   input  logic [31:0]               data_bus_rd,
   output logic                      wr_strobe,
   output logic                      rd_strobe,
   output logic [NUM_MASTERS-1:0]    grant
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_WAIT   = 2'd2,
      ST_ACK    = 2'd3
   } state_t;

   state_t                 state_q,       state_d;
   logic [IDX_W-1:0]       rr_last_q,     rr_last_d;
   logic [IDX_W-1:0]       win_q,         win_d;
   logic                   we_q,          we_d;
   logic [CNT_W-1:0]       cnt_q,         cnt_d;
   logic [NUM_MASTERS-1:0] m_ack_q,       m_ack_d;
   logic [31:0]            m_rdata_q,     m_rdata_d;
   logic [30:0]            addr_bus_q,    addr_bus_d;
   logic [31:0]            data_bus_wr_q, data_bus_wr_d;
   logic                   wr_strobe_q,   wr_strobe_d;
   logic                   rd_strobe_q,   rd_strobe_d;
   logic [NUM_MASTERS-1:0] grant_q,       grant_d;

   logic [NUM_MASTERS-1:0] elig_s;
   logic                   found_s;
   logic [IDX_W-1:0]       pick_s;
   logic [IDX_W-1:0]       idx_s;

`ifdef ADDR_ARB_LOCK_EN
   logic                   lock_q, lock_d;
`else
   logic                   unused_lock_s;
   assign unused_lock_s = ^m_lock;
`endif

   function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_MASTERS-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

   // Eligible requesters: under a live lock only the current owner may compete.
   always_comb begin
      elig_s = m_req;
`ifdef ADDR_ARB_LOCK_EN
      // The lock is live only while the owner keeps m_lock high.
      // Dropping it in IDLE frees the bus in that same cycle.
      if (lock_q && m_lock[win_q]) begin
         elig_s        = '0;
         elig_s[win_q] = m_req[win_q];
      end else begin
         elig_s = m_req;
      end
`endif
   end

   // Round-robin search: first eligible master upward from rr_last+1, wrapping.
   always_comb begin
      found_s = 1'b0;
      pick_s  = rr_last_q;
      idx_s   = rr_last_q;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx_s = IDX_W'((int'(rr_last_q) + i) % NUM_MASTERS);
         if (!found_s && elig_s[idx_s]) begin
            found_s = 1'b1;
            pick_s  = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state logic of the bus-cycle sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               state_d = ST_STROBE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STROBE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = ST_ACK;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output/datapath logic.
   // Every output is computed one cycle ahead, so all outputs come straight
   // from flops.
   always_comb begin
      rr_last_d     = rr_last_q;
      win_d         = win_q;
      we_d          = we_q;
      cnt_d         = cnt_q;
      m_ack_d       = '0;
      m_rdata_d     = m_rdata_q;
      addr_bus_d    = addr_bus_q;
      data_bus_wr_d = data_bus_wr_q;
      wr_strobe_d   = 1'b0;
      rd_strobe_d   = 1'b0;
      grant_d       = grant_q;
`ifdef ADDR_ARB_LOCK_EN
      lock_d        = lock_q;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef ADDR_ARB_LOCK_EN
            if (lock_q && !m_lock[win_q]) begin
               lock_d = 1'b0;
            end else begin
               lock_d = lock_q;
            end
`endif
            if (found_s) begin
               win_d         = pick_s;
               rr_last_d     = pick_s;
               we_d          = m_we[pick_s];
               addr_bus_d    = m_addr[31*int'(pick_s) +: 31];
               data_bus_wr_d = m_wdata[32*int'(pick_s) +: 32];
               grant_d       = onehot(pick_s);
               wr_strobe_d   = m_we[pick_s];
               rd_strobe_d   = !m_we[pick_s];
            end else begin
               addr_bus_d    = 31'h0;
               data_bus_wr_d = 32'h0;
               grant_d       = '0;
            end
         end
         ST_STROBE: begin
            cnt_d = CNT_W'(RD_LATENCY - 1);
         end
         ST_WAIT: begin
            if (cnt_q == 3'd0) begin
               // Writes return zero; the read bus is not meaningful for them.
               m_rdata_d = we_q ? 32'h0 : data_bus_rd;
               m_ack_d   = onehot(win_q);
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_ACK: begin
            addr_bus_d    = 31'h0;
            data_bus_wr_d = 32'h0;
            grant_d       = '0;
`ifdef ADDR_ARB_LOCK_EN
            lock_d        = m_lock[win_q];
`endif
         end
         default: begin
            addr_bus_d    = 31'h0;
            data_bus_wr_d = 32'h0;
            grant_d       = '0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers.
   // Reset clears any bus cycle in flight, so no ack is ever delivered for it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_last_q     <= IDX_W'(NUM_MASTERS - 1);
         win_q         <= '0;
         we_q          <= 1'b0;
         cnt_q         <= 3'd0;
         m_ack_q       <= '0;
         m_rdata_q     <= 32'h0;
         addr_bus_q    <= 31'h0;
         data_bus_wr_q <= 32'h0;
         wr_strobe_q   <= 1'b0;
         rd_strobe_q   <= 1'b0;
         grant_q       <= '0;
      end else begin
         rr_last_q     <= rr_last_d;
         win_q         <= win_d;
         we_q          <= we_d;
         cnt_q         <= cnt_d;
         m_ack_q       <= m_ack_d;
         m_rdata_q     <= m_rdata_d;
         addr_bus_q    <= addr_bus_d;
         data_bus_wr_q <= data_bus_wr_d;
         wr_strobe_q   <= wr_strobe_d;
         rd_strobe_q   <= rd_strobe_d;
         grant_q       <= grant_d;
      end
   end

`ifdef ADDR_ARB_LOCK_EN
   // Lock-held flag for the current owner.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
      end
   end
`endif

   assign m_ack       = m_ack_q;
   assign m_rdata     = m_rdata_q;
   assign addr_bus    = addr_bus_q;
   assign data_bus_wr = data_bus_wr_q;
   assign wr_strobe   = wr_strobe_q;
   assign rd_strobe   = rd_strobe_q;
   assign grant       = grant_q;

endmodule
